// File: rtl/ecc_pkg.sv
// Shared header-ECC definitions: Hamming parity masks, syndrome columns and decode status.
// Used by the RX checker and the TX ECC generator.
package ecc_pkg;

  localparam int unsigned DIN_W = 24;
  localparam int unsigned PAR_W = 6;

  // Each mask selects the din bits that feed one ecc parity bit.
  localparam logic [DIN_W-1:0] PAR_MASK [0:PAR_W-1] = '{
    24'hF12CB7,
    24'hF2555B,
    24'h749A6D,
    24'hB8E38E,
    24'hDF03F0,
    24'hEFFC00
  };

  // Syndrome produced by a single flipped din bit; transpose of PAR_MASK.
  localparam logic [PAR_W-1:0] COL [0:DIN_W-1] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C,
    6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38,
    6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  typedef enum logic [1:0] {
    SYN_OK     = 2'd0,
    SYN_CORR   = 2'd1,
    SYN_UNCORR = 2'd2
  } syn_status_e;

  function automatic logic [PAR_W-1:0] ecc_calc(input logic [DIN_W-1:0] din);
    logic [PAR_W-1:0] p;
    p = '0;
    for (int i = 0; i < PAR_W; i++) begin
      p[i] = ^(din & PAR_MASK[i]);
    end
    return p;
  endfunction

endpackage

// File: rtl/ecc_syn_dec.sv
// Combinational syndrome decoder: maps a 6-bit syndrome to a din flip mask and a status.
module ecc_syn_dec
  import ecc_pkg::*;
(
  input  logic [PAR_W-1:0] syn_i,
  output logic [DIN_W-1:0] flip_mask_o,
  output syn_status_e      status_o
);

  always_comb begin
    flip_mask_o = '0;
    status_o    = SYN_UNCORR;
    if (syn_i == '0) begin
      status_o = SYN_OK;
    end else if ($onehot(syn_i)) begin
      // A lone syndrome bit means the ecc byte itself took the hit; data is intact.
      status_o = SYN_CORR;
    end else begin
      for (int i = 0; i < DIN_W; i++) begin
        if (syn_i == COL[i]) begin
          flip_mask_o[i] = 1'b1;
          status_o       = SYN_CORR;
        end
      end
    end
  end

endmodule

// File: rtl/ecc_chk.sv
// Receive-side packet-header ECC checker/corrector: two-stage valid/ready pipeline
// with saturating corrected/uncorrectable error counters.
module ecc_chk
  import ecc_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter bit          RSVD_CHK = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_hdr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_hdr,
  output logic             out_ok,
  output logic             out_corr,
  output logic             out_uncorr,
  output logic             out_rsvd_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  logic             s1_valid_q, s1_valid_d;
  logic [DIN_W-1:0] s1_din_q, s1_din_d;
  logic [1:0]       s1_rsvd_q, s1_rsvd_d;
  logic [PAR_W-1:0] s1_syn_q, s1_syn_d;

  logic             out_valid_q, out_valid_d;
  logic [DIN_W-1:0] out_hdr_q, out_hdr_d;
  logic             out_ok_q, out_ok_d;
  logic             out_corr_q, out_corr_d;
  logic             out_uncorr_q, out_uncorr_d;
  logic             out_rsvd_q, out_rsvd_d;

  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  logic             s1_adv, s2_adv, in_accept, out_xfer;
  logic [DIN_W-1:0] flip_mask;
  syn_status_e      dec_status;

  ecc_syn_dec u_syn_dec (
    .syn_i       (s1_syn_q),
    .flip_mask_o (flip_mask),
    .status_o    (dec_status)
  );

  assign s2_adv    = !out_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = !reset && s1_adv;
  assign in_accept = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;

  // Stage 1: capture din, reserved ecc bits and the syndrome.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_din_d   = s1_din_q;
    s1_rsvd_d  = s1_rsvd_q;
    s1_syn_d   = s1_syn_q;
    if (s1_adv) begin
      s1_valid_d = in_accept;
      if (in_accept) begin
        s1_din_d  = in_hdr[23:0];
        s1_rsvd_d = in_hdr[31:30];
        s1_syn_d  = ecc_calc(in_hdr[23:0]) ^ in_hdr[29:24];
      end
    end
  end

  // Stage 2: register the decoded result; flags are only ever set alongside out_valid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_hdr_d    = out_hdr_q;
    out_ok_d     = out_ok_q;
    out_corr_d   = out_corr_q;
    out_uncorr_d = out_uncorr_q;
    out_rsvd_d   = out_rsvd_q;
    if (s2_adv) begin
      out_valid_d  = s1_valid_q;
      out_ok_d     = s1_valid_q && (dec_status == SYN_OK);
      out_corr_d   = s1_valid_q && (dec_status == SYN_CORR);
      out_uncorr_d = s1_valid_q && (dec_status == SYN_UNCORR);
      out_rsvd_d   = s1_valid_q && RSVD_CHK && (|s1_rsvd_q);
      if (s1_valid_q) begin
        out_hdr_d = s1_din_q ^ flip_mask;
      end
    end
  end

  // Clear wins over a same-cycle increment; the coincident event is dropped.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_xfer) begin
      if (out_corr_q && !(&corr_cnt_q)) begin
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      end
      if (out_uncorr_q && !(&uncorr_cnt_q)) begin
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_din_q     <= '0;
      s1_rsvd_q    <= '0;
      s1_syn_q     <= '0;
      out_valid_q  <= 1'b0;
      out_hdr_q    <= '0;
      out_ok_q     <= 1'b0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
      out_rsvd_q   <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_din_q     <= s1_din_d;
      s1_rsvd_q    <= s1_rsvd_d;
      s1_syn_q     <= s1_syn_d;
      out_valid_q  <= out_valid_d;
      out_hdr_q    <= out_hdr_d;
      out_ok_q     <= out_ok_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
      out_rsvd_q   <= out_rsvd_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_hdr      = out_hdr_q;
  assign out_ok       = out_ok_q;
  assign out_corr     = out_corr_q;
  assign out_uncorr   = out_uncorr_q;
  assign out_rsvd_err = out_rsvd_q;
  assign corr_cnt     = corr_cnt_q;
  assign uncorr_cnt   = uncorr_cnt_q;

endmodule

// File: tb/tb_ecc_chk.sv
// Directed self-checking bench for ecc_chk; a second instance (CNT_W=2, RSVD_CHK=0)
// shares the stimulus to cover counter saturation and reserved-bit gating.
module tb_ecc_chk;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, cnt_clr;
  logic [31:0] in_hdr;

  logic        in_ready, out_valid, out_ok, out_corr, out_uncorr, out_rsvd_err;
  logic [23:0] out_hdr;
  logic [15:0] corr_cnt, uncorr_cnt;

  logic        s_in_ready, s_out_valid, s_ok, s_corr, s_uncorr, s_rsvd;
  logic [23:0] s_out_hdr;
  logic [1:0]  s_corr_cnt, s_uncorr_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_corr = 0, exp_uncorr = 0, exp_scorr = 0, exp_suncorr = 0;

  localparam logic [5:0] COLT [0:7] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19};

  ecc_chk dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_hdr       (in_hdr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_hdr      (out_hdr),
    .out_ok       (out_ok),
    .out_corr     (out_corr),
    .out_uncorr   (out_uncorr),
    .out_rsvd_err (out_rsvd_err),
    .cnt_clr      (cnt_clr),
    .corr_cnt     (corr_cnt),
    .uncorr_cnt   (uncorr_cnt)
  );

  ecc_chk #(
    .CNT_W    (2),
    .RSVD_CHK (1'b0)
  ) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (s_in_ready),
    .in_hdr       (in_hdr),
    .out_valid    (s_out_valid),
    .out_ready    (out_ready),
    .out_hdr      (s_out_hdr),
    .out_ok       (s_ok),
    .out_corr     (s_corr),
    .out_uncorr   (s_uncorr),
    .out_rsvd_err (s_rsvd),
    .cnt_clr      (cnt_clr),
    .corr_cnt     (s_corr_cnt),
    .uncorr_cnt   (s_uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_xfer(input int st);
    if (st == 1) begin
      exp_corr  = sat_inc(exp_corr, 65535);
      exp_scorr = sat_inc(exp_scorr, 3);
    end else if (st == 2) begin
      exp_uncorr  = sat_inc(exp_uncorr, 65535);
      exp_suncorr = sat_inc(exp_suncorr, 3);
    end
  endtask

  task automatic check_cnts(input string tag);
    check({tag, " corr_cnt"}, 32'(corr_cnt), 32'(exp_corr));
    check({tag, " uncorr_cnt"}, 32'(uncorr_cnt), 32'(exp_uncorr));
    check({tag, " sat corr_cnt"}, 32'(s_corr_cnt), 32'(exp_scorr));
    check({tag, " sat uncorr_cnt"}, 32'(s_uncorr_cnt), 32'(exp_suncorr));
  endtask

  // Called #1 after a rising edge with an empty pipeline and out_ready high.
  // st: 0 = ok, 1 = corrected, 2 = uncorrectable.
  task automatic run_one(input string tag, input logic [31:0] hdr, input logic [23:0] exp_hdr,
                         input int st, input bit exp_rsvd, input bit clr);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_hdr   = hdr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " out_hdr"}, 32'(out_hdr), 32'(exp_hdr));
    check({tag, " ok/corr/uncorr"}, {29'd0, out_uncorr, out_corr, out_ok},
          (st == 0) ? 32'd1 : (st == 1) ? 32'd2 : 32'd4);
    check({tag, " rsvd_err"}, 32'(out_rsvd_err), 32'(exp_rsvd));
    check({tag, " sat rsvd_err"}, 32'(s_rsvd), 32'd0);
    cnt_clr = clr;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    if (clr) begin
      exp_corr = 0; exp_uncorr = 0; exp_scorr = 0; exp_suncorr = 0;
    end else begin
      model_xfer(st);
    end
    check_cnts(tag);
  endtask

  logic [31:0] words [8];
  logic [23:0] exp_o [8];
  int          exp_s [8];

  initial begin
    int          iidx, oidx;
    bit          held, saw_stall;
    logic [23:0] held_hdr;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; in_hdr = '0;
    @(posedge clk); #1;
    check("in_ready in reset", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);
    check("out_valid after reset", 32'(out_valid), 32'd0);
    check("out_hdr after reset", 32'(out_hdr), 32'd0);
    check("flags after reset", {28'd0, out_rsvd_err, out_uncorr, out_corr, out_ok}, 32'd0);
    check_cnts("reset");
    @(posedge clk); #1;

    run_one("clean 0x07000001", 32'h07_000001, 24'h000001, 0, 1'b0, 1'b0);
    run_one("clean zero", 32'h00_000000, 24'h000000, 0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [23:0] d;
      d = 24'h000001 ^ (24'h1 << i);
      run_one($sformatf("din bit %0d", i), {8'h07, d}, 24'h000001, 1, 1'b0, 1'b0);
    end
    for (int j = 0; j < 6; j++) begin
      logic [7:0] e;
      e = 8'h07 ^ (8'h1 << j);
      run_one($sformatf("ecc bit %0d", j), {e, 24'h000001}, 24'h000001, 1, 1'b0, 1'b0);
    end

    run_one("double 0x0C", 32'h0C_000000, 24'h000000, 2, 1'b0, 1'b0);
    run_one("multi 0x3F", 32'h3F_0000A5, 24'h0000A5, 2, 1'b0, 1'b0);
    run_one("rsvd 0xC7000001", 32'hC7_000001, 24'h000001, 0, 1'b1, 1'b0);

    // Back-to-back stream with a three-cycle downstream stall.
    for (int k = 0; k < 8; k++) begin
      words[k] = {2'b00, COLT[k], 24'h1 << k};
      exp_o[k] = 24'h1 << k;
      exp_s[k] = 0;
    end
    words[3] = {2'b00, COLT[3], 24'h000009};
    exp_s[3] = 1;
    iidx = 0; oidx = 0; held = 1'b0; saw_stall = 1'b0; held_hdr = '0;
    for (int cyc = 0; cyc < 40 && oidx < 8; cyc++) begin
      in_valid = (iidx < 8);
      if (iidx < 8) in_hdr = words[iidx];
      out_ready = !(cyc >= 4 && cyc < 7);
      #1;
      if (held) begin
        check($sformatf("stream hold valid c%0d", cyc), 32'(out_valid), 32'd1);
        check($sformatf("stream hold hdr c%0d", cyc), 32'(out_hdr), 32'(held_hdr));
      end
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        check($sformatf("stream hdr %0d", oidx), 32'(out_hdr), 32'(exp_o[oidx]));
        check($sformatf("stream corr %0d", oidx), 32'(out_corr), 32'(exp_s[oidx]));
        model_xfer(exp_s[oidx]);
        oidx++;
      end
      held     = out_valid && !out_ready;
      held_hdr = out_hdr;
      if (in_valid && in_ready) iidx++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream count", 32'(oidx), 32'd8);
    check("stream in_ready dropped", 32'(saw_stall), 32'd1);
    check("stream drained", 32'(out_valid), 32'd0);
    check_cnts("stream");

    // Counter clear, saturation on the 2-bit instance, clear beating an increment.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_corr = 0; exp_uncorr = 0; exp_scorr = 0; exp_suncorr = 0;
    check_cnts("cnt_clr");
    for (int n = 0; n < 5; n++) begin
      run_one($sformatf("sat corr %0d", n), 32'h07_000000, 24'h000001, 1, 1'b0, 1'b0);
    end
    check("sat stuck at 3", 32'(s_corr_cnt), 32'd3);
    run_one("clr with corr", 32'h07_000000, 24'h000001, 1, 1'b0, 1'b1);

    // Reset with two words in flight.
    run_one("pre-reset corr", 32'h07_000000, 24'h000001, 1, 1'b0, 1'b0);
    in_valid  = 1'b1;
    in_hdr    = 32'h07_000000;
    @(posedge clk); #1;
    in_hdr    = 32'h0C_000000;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    exp_corr = 0; exp_uncorr = 0; exp_scorr = 0; exp_suncorr = 0;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd0);
    check("mid reset out_hdr", 32'(out_hdr), 32'd0);
    check_cnts("mid reset");
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("post reset out_valid a", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("post reset out_valid b", 32'(out_valid), 32'd0);
    check_cnts("post reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
